integral_image_gen: RTL and testbench

//  Streaming integral-image generator for the face-detection pipeline. Sits directly downstream of
//  the RGB->grayscale luma stage. Consumes one luma pixel per handshake in raster order and emits
//  ii(x,y) = sum of all pixels p(i,j) with i<=x and j<=y. The Viola-Jones feature evaluator reads ii.

---
 rtl/face_det_pkg.sv | 20 ++
 rtl/ii_line_buf.sv | 26 ++
 rtl/integral_image_gen.sv | 129 ++++++++++++
 tb/tb_integral_image_gen.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/face_det_pkg.sv
// Shared definitions for the face-detection pipeline: frame geometry defaults,
// FSM state type and the luma pre-scale helper.
package face_det_pkg;

    localparam int unsigned IMG_W_DEF    = 640;
    localparam int unsigned IMG_H_DEF    = 480;
    localparam int unsigned PIX_W_DEF    = 20;
    localparam int unsigned IN_SHIFT_DEF = 12;
    localparam int unsigned ACC_W_DEF    = 32;

    typedef enum logic {
        StIdle,
        StRun
    } state_t;

    function automatic logic [63:0] luma_scale(input logic [63:0] pix, input int unsigned shift);
        return pix >> shift;
    endfunction

endpackage

// File: rtl/ii_line_buf.sv
// One-row buffer of integral values: single write port, asynchronous read port.
// A same-cycle read of the written address returns the old contents.
module ii_line_buf #(
    parameter int unsigned Depth = 640,
    parameter int unsigned Width = 32,
    localparam int unsigned AW   = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    assign rdata_o = mem_q[raddr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/integral_image_gen.sv
// Streaming integral-image generator: one luma pixel in, one ii(x,y) out per
// handshake, using a running row sum plus the previous row held in a line buffer.
module integral_image_gen
    import face_det_pkg::*;
#(
    parameter int unsigned IMG_W    = IMG_W_DEF,
    parameter int unsigned IMG_H    = IMG_H_DEF,
    parameter int unsigned PIX_W    = PIX_W_DEF,
    parameter int unsigned IN_SHIFT = IN_SHIFT_DEF,
    parameter int unsigned ACC_W    = ACC_W_DEF,
    localparam int unsigned XW      = $clog2(IMG_W),
    localparam int unsigned YW      = $clog2(IMG_H)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_ii,
    output logic [XW-1:0]    out_x,
    output logic [YW-1:0]    out_y,
    output logic             out_eof,
    output logic             frame_err
);

    state_t           state_q;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic [ACC_W-1:0] row_sum_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_ii_q;
    logic [XW-1:0]    out_x_q;
    logic [YW-1:0]    out_y_q;
    logic             out_eof_q;
    logic             frame_err_q;

    logic             accept;
    logic             valid_pix;
    logic             sof_err;
    logic             x_last;
    logic             y_last;
    logic [XW-1:0]    cur_x;
    logic [YW-1:0]    cur_y;
    logic [ACC_W-1:0] pix_scaled;
    logic [ACC_W-1:0] row_sum;
    logic [ACC_W-1:0] lb_rdata;
    logic [ACC_W-1:0] ii;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    // In IDLE only an sof pixel is real; everything else is dropped silently.
    assign valid_pix = accept && (in_sof || (state_q == StRun));
    assign sof_err   = accept && in_sof && (state_q == StRun) && ((x_q != '0) || (y_q != '0));

    // An sof pixel always restarts the frame at the origin.
    assign cur_x  = in_sof ? '0 : x_q;
    assign cur_y  = in_sof ? '0 : y_q;
    assign x_last = (cur_x == XW'(IMG_W - 1));
    assign y_last = (cur_y == YW'(IMG_H - 1));

    assign pix_scaled = ACC_W'(luma_scale(64'(in_pix), IN_SHIFT));
    assign row_sum    = ((cur_x == '0) ? '0 : row_sum_q) + pix_scaled;
    assign ii         = row_sum + ((cur_y == '0) ? '0 : lb_rdata);

    ii_line_buf #(
        .Depth (IMG_W),
        .Width (ACC_W)
    ) u_line_buf (
        .clk_i   (Clk),
        .we_i    (valid_pix),
        .waddr_i (cur_x),
        .wdata_i (ii),
        .raddr_i (cur_x),
        .rdata_o (lb_rdata)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            x_q         <= '0;
            y_q         <= '0;
            row_sum_q   <= '0;
            out_valid_q <= 1'b0;
            out_ii_q    <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_eof_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= sof_err;
            if (valid_pix) begin
                out_valid_q <= 1'b1;
                out_ii_q    <= ii;
                out_x_q     <= cur_x;
                out_y_q     <= cur_y;
                out_eof_q   <= x_last && y_last;
                row_sum_q   <= row_sum;
                if (x_last) begin
                    x_q <= '0;
                    if (y_last) begin
                        y_q     <= '0;
                        state_q <= StIdle;
                    end else begin
                        y_q     <= cur_y + 1'b1;
                        state_q <= StRun;
                    end
                end else begin
                    x_q     <= cur_x + 1'b1;
                    y_q     <= cur_y;
                    state_q <= StRun;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
                out_eof_q   <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ii    = out_ii_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_eof   = out_eof_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_integral_image_gen.sv
// Directed bench for integral_image_gen on a 4x3 frame: raster sums, back-pressure,
// IDLE discard, mid-frame restart, default input scaling and asynchronous reset.
module tb_integral_image_gen;

    localparam int unsigned W = 4;
    localparam int unsigned H = 3;

    typedef struct {
        logic [31:0] ii;
        logic [1:0]  x;
        logic [1:0]  y;
        logic        eof;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        in_valid, in_ready, in_sof, out_valid, out_ready, out_eof, frame_err;
    logic [19:0] in_pix;
    logic [31:0] out_ii;
    logic [1:0]  out_x, out_y;

    logic        in_valid2, in_ready2, in_sof2, out_valid2, out_eof2, frame_err2;
    logic [19:0] in_pix2;
    logic [31:0] out_ii2;
    logic [1:0]  out_x2, out_y2;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ferr_cnt = 0;
    logic toggle_en = 1'b0;

    integral_image_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(20), .IN_SHIFT(0), .ACC_W(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pix(in_pix), .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready),
        .out_ii(out_ii), .out_x(out_x), .out_y(out_y), .out_eof(out_eof),
        .frame_err(frame_err)
    );

    integral_image_gen #(.IMG_W(W), .IMG_H(H)) dut_def (
        .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_pix(in_pix2), .in_sof(in_sof2), .out_valid(out_valid2), .out_ready(1'b1),
        .out_ii(out_ii2), .out_x(out_x2), .out_y(out_y2), .out_eof(out_eof2),
        .frame_err(frame_err2)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_out(input int ii, input int x, input int y, input bit eof);
        exp_t e;
        e.ii  = 32'(ii);
        e.x   = 2'(x);
        e.y   = 2'(y);
        e.eof = eof;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the pixel was accepted.
    task automatic send(input int pix, input bit sof);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_pix   = 20'(pix);
        in_sof   = sof;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge Clk);
            done = in_ready;
            @(posedge Clk);
            #1;
        end
        if (!done) check_eq("send_timeout", in_ready, 1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge Clk);
            #1;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    task automatic frame_of_ones();
        for (int i = 0; i < 12; i++) begin
            expect_out((i % 4 + 1) * (i / 4 + 1), i % 4, i / 4, i == 11);
            send(1, i == 0);
        end
        wait_drain();
    endtask

    always @(negedge Clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", out_valid, 0);
            end else begin
                check_eq("ii", out_ii, exp_q[0].ii);
                check_eq("x", out_x, exp_q[0].x);
                check_eq("y", out_y, exp_q[0].y);
                check_eq("eof", out_eof, exp_q[0].eof);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        if (frame_err) ferr_cnt++;
    end

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (toggle_en) out_ready = ~out_ready;
        end
    end

    int ramp_ii [12] = '{0, 1, 3, 6, 4, 10, 18, 28, 12, 27, 45, 66};
    int rst_ii  [12] = '{8, 9, 10, 8, 10, 12, 14, 9, 12, 15, 18, 0};

    initial begin
        Reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_pix    = '0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        in_valid2 = 1'b0;
        in_pix2   = '0;
        in_sof2   = 1'b0;
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_ii", out_ii, 0);
        check_eq("rst_xy", {out_x, out_y}, 0);
        check_eq("rst_eof", out_eof, 0);
        check_eq("rst_ferr", frame_err, 0);
        check_eq("rst_ready", in_ready, 1);
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // All ones: ii = (x+1)*(y+1)
        frame_of_ones();

        // Ramp pixels with toggling back-pressure
        toggle_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            expect_out(ramp_ii[i], i % 4, i / 4, i == 11);
            send(i, i == 0);
        end
        wait_drain();
        toggle_en = 1'b0;
        out_ready = 1'b1;
        @(posedge Clk);
        #1;

        // Pixels without sof in IDLE are dropped
        for (int i = 0; i < 3; i++) begin
            check_eq("idle_ready", in_ready, 1);
            send(5, 1'b0);
        end
        check_eq("idle_no_out", out_valid, 0);
        frame_of_ones();

        // Restart on the 6th pixel with value 7
        ferr_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            expect_out((i % 4 + 1) * (i / 4 + 1), i % 4, i / 4, 1'b0);
            send(1, i == 0);
        end
        expect_out(7, 0, 0, 1'b0);
        send(7, 1'b1);
        for (int i = 1; i < 12; i++) begin
            expect_out(rst_ii[i - 1], i % 4, i / 4, i == 11);
            send(1, 1'b0);
        end
        wait_drain();
        check_eq("ferr_pulses", ferr_cnt, 1);

        // Asynchronous reset mid row 1 with an output pending
        for (int i = 0; i < 5; i++) begin
            expect_out((i % 4 + 1) * (i / 4 + 1), i % 4, i / 4, 1'b0);
            send(1, i == 0);
        end
        check_eq("pre_rst_valid", out_valid, 1);
        Reset_n = 1'b0;
        #1;
        check_eq("async_rst_valid", out_valid, 0);
        check_eq("async_rst_ii", out_ii, 0);
        check_eq("async_rst_xy", {out_x, out_y}, 0);
        exp_q.delete();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        frame_of_ones();

        // Default IN_SHIFT: 1_000_000 >> 12 = 244
        for (int i = 0; i < 12; i++) begin
            in_valid2 = 1'b1;
            in_pix2   = 20'd1_000_000;
            in_sof2   = (i == 0);
            @(negedge Clk);
            check_eq("def_ready", in_ready2, 1);
            @(posedge Clk);
            #1;
            check_eq("def_valid", out_valid2, 1);
            check_eq("def_ii", out_ii2, 244 * (i % 4 + 1) * (i / 4 + 1));
            check_eq("def_eof", out_eof2, i == 11);
        end
        in_valid2 = 1'b0;
        in_sof2   = 1'b0;
        @(posedge Clk);
        #1;
        check_eq("def_idle", out_valid2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
